// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Definitions shared by the ALU command driver and the ALU generator outputs:
//   opcode encodings, default datapath widths, the response record layout and
//   small opcode-classification helpers.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Opcode encodings understood by the pipelined ALU
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_SRL = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_MAX = 4'd4;

  // Default field widths of the ALU port and of a response record
  localparam int ALU_WIDTH = 128;
  localparam int ALU_SHW   = 5;
  localparam int ALU_TAGW  = 4;
  localparam int RSP_FLAGW = 4;

  // Response record as stored in the response FIFO (MSB first)
  typedef struct packed {
    logic                err;
    logic                sign;
    logic                zero;
    logic                carry;
    logic [ALU_TAGW-1:0]  tag;
    logic [ALU_WIDTH-1:0] result;
  } alu_rsp_t;

  // Opcodes above OP_MAX are issued anyway but flagged in the response
  function automatic logic op_illegal(input logic [3:0] op);
    return (op > OP_MAX);
  endfunction

  // Only ADD and SUB produce a meaningful carry/borrow from the ALU
  function automatic logic op_has_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_driver_chk.sv
// -----------------------------------------------------------------------------
// alu_cmd_driver_chk
//   Property checker for the command driver. The credit scheme must make a
//   push into a full response FIFO impossible.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   push        pipe writes a response this cycle
//   full        response FIFO is full
// -----------------------------------------------------------------------------
module alu_cmd_driver_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic full
);

  no_fifo_overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/alu_rsp_fifo.sv
// -----------------------------------------------------------------------------
// alu_rsp_fifo
//   Synchronous response FIFO. Push and pop in the same cycle are legal at any
//   occupancy; pointers wrap naturally because DEPTH is a power of two.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write request and data
//   pop             read request (head is consumed at the edge)
//   pop_data        current head entry
//   empty, full     occupancy status
//   count           number of stored entries
// -----------------------------------------------------------------------------
module alu_rsp_fifo #(
  parameter int DW    = 140,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          wr_en_s;
  logic          rd_en_s;

  // A pop frees the slot in the same edge, so a push to a full FIFO with a pop is safe
  assign rd_en_s  = pop & ~empty;
  assign wr_en_s  = push & (~full | rd_en_s);
  assign empty    = (count_r == '0);
  assign full     = (count_r == (AW+1)'(DEPTH));
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Storage array, pointers and occupancy counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// alu_cmd_driver
//   Issue side of a pipelined ALU. Accepts tagged commands (valid/ready),
//   drives one op per cycle into the ALU through registered outputs, tracks
//   in-flight ops over ALU_LAT cycles and captures result, tag and flags into
//   a response FIFO returned on a valid/ready channel.
//   An op accepted at edge k is in stage 0 during cycle k+1 and in the last
//   stage during cycle k+ALU_LAT, when alu_result/alu_carry are sampled; its
//   response is visible from cycle k+ALU_LAT+1 if the FIFO was empty.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/ready            command handshake
//   cmd_opcode/a/b/shift/tag   command fields
//   alu_opcode/input1/input2/shift  registered ALU inputs
//   alu_result, alu_carry      ALU outputs
//   rsp_valid/ready            response handshake
//   rsp_result/carry/zero/sign/tag/err  response fields
//   busy                       ops in flight or responses pending
// -----------------------------------------------------------------------------
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter int SHW        = ALU_SHW,
  parameter int TAGW       = ALU_TAGW,
  parameter int ALU_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SHW-1:0]   cmd_shift,
  input  logic [TAGW-1:0]  cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [SHW-1:0]   alu_shift,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_sign,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam int DW  = WIDTH + TAGW + RSP_FLAGW;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW  = $clog2(FIFO_DEPTH + ALU_LAT + 1) + 1;

  logic [ALU_LAT-1:0] pipe_v_r;
  logic [TAGW-1:0]    pipe_tag_r [ALU_LAT];
  logic [3:0]         pipe_op_r  [ALU_LAT];

  logic               accept_s;
  logic               push_s;
  logic [3:0]         last_op_s;
  logic [DW-1:0]      push_data_s;
  logic [DW-1:0]      fifo_head_s;
  logic               fifo_empty_s;
  logic               fifo_full_s;
  logic [FCW-1:0]     fifo_cnt_s;
  logic [CW-1:0]      inflight_cnt_s;
  logic               credit_s;

  assign accept_s = cmd_valid & cmd_ready;

  // Number of ops currently travelling through the ALU
  always_comb begin
    inflight_cnt_s = '0;
    for (int i = 0; i < ALU_LAT; i++) begin
      inflight_cnt_s = inflight_cnt_s + CW'(pipe_v_r[i]);
    end
  end

  // Every in-flight op owns a FIFO slot; pops in this cycle are not credited
  // so that cmd_ready has no combinational dependence on rsp_ready.
  assign credit_s  = (CW'(fifo_cnt_s) + inflight_cnt_s) < CW'(FIFO_DEPTH);
  assign cmd_ready = rst_n & credit_s;
  assign busy      = (|pipe_v_r) | ~fifo_empty_s;

  // ALU input registers: load on accept, otherwise hold to avoid toggling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= 4'd0;
      alu_input1 <= '0;
      alu_input2 <= '0;
      alu_shift  <= '0;
    end else if (accept_s) begin
      alu_opcode <= cmd_opcode;
      alu_input1 <= cmd_a;
      alu_input2 <= cmd_b;
      alu_shift  <= cmd_shift;
    end
  end

  // In-flight shift register, aligned with the ALU latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_r <= '0;
      for (int i = 0; i < ALU_LAT; i++) begin
        pipe_tag_r[i] <= '0;
        pipe_op_r[i]  <= 4'd0;
      end
    end else begin
      pipe_v_r[0]   <= accept_s;
      pipe_tag_r[0] <= cmd_tag;
      pipe_op_r[0]  <= cmd_opcode;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_v_r[i]   <= pipe_v_r[i-1];
        pipe_tag_r[i] <= pipe_tag_r[i-1];
        pipe_op_r[i]  <= pipe_op_r[i-1];
      end
    end
  end

  // Response record; zero/sign are derived locally from the result
  assign push_s      = pipe_v_r[ALU_LAT-1];
  assign last_op_s   = pipe_op_r[ALU_LAT-1];
  assign push_data_s = {op_illegal(last_op_s),
                        alu_result[WIDTH-1],
                        (alu_result == '0),
                        alu_carry & op_has_carry(last_op_s),
                        pipe_tag_r[ALU_LAT-1],
                        alu_result};

  alu_rsp_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (rsp_ready),
    .pop_data  (fifo_head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (fifo_cnt_s)
  );

  assign rsp_valid = ~fifo_empty_s;
  assign {rsp_err, rsp_sign, rsp_zero, rsp_carry, rsp_tag, rsp_result} = fifo_head_s;

  alu_cmd_driver_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .full  (fifo_full_s)
  );

endmodule

// File: tb/tb_alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_driver
//   Directed and randomly throttled checks of alu_cmd_driver against a
//   behavioural pipelined ALU and an in-order scoreboard.
// -----------------------------------------------------------------------------
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_opcode;
  logic [127:0] cmd_a;
  logic [127:0] cmd_b;
  logic [4:0]   cmd_shift;
  logic [3:0]   cmd_tag;
  logic [3:0]   alu_opcode;
  logic [127:0] alu_input1;
  logic [127:0] alu_input2;
  logic [4:0]   alu_shift;
  logic [127:0] alu_result;
  logic         alu_carry;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_result;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_sign;
  logic [3:0]   rsp_tag;
  logic         rsp_err;
  logic         busy;

  typedef struct packed {
    logic [127:0] r;
    logic         c;
    logic         z;
    logic         s;
    logic         e;
    logic [3:0]   tag;
  } rsp_t;

  rsp_t got_q[$];
  rsp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  alu_cmd_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_shift  (cmd_shift),
    .cmd_tag    (cmd_tag),
    .alu_opcode (alu_opcode),
    .alu_input1 (alu_input1),
    .alu_input2 (alu_input2),
    .alu_shift  (alu_shift),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_sign   (rsp_sign),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: {carry/borrow, result}
  function automatic logic [128:0] alu_calc(input logic [3:0] op, input logic [127:0] a,
                                            input logic [127:0] b, input logic [4:0] sh);
    logic [127:0] m;
    logic [128:0] t;
    case (op)
      OP_ADD:  t = {1'b0, a} + {1'b0, b};
      OP_SUB:  t = {1'b0, a} - {1'b0, b};
      OP_MUL:  begin m = a * b; t = {1'b0, m}; end
      OP_SRL:  t = {1'b0, a >> sh};
      OP_SLL:  t = {1'b0, a << sh};
      default: t = 129'd0;
    endcase
    return t;
  endfunction

  function automatic rsp_t exp_rsp(input logic [3:0] op, input logic [127:0] a, input logic [127:0] b,
                                   input logic [4:0] sh, input logic [3:0] tag);
    logic [128:0] t;
    rsp_t x;
    t     = alu_calc(op, a, b, sh);
    x.r   = t[127:0];
    x.c   = (op == OP_ADD || op == OP_SUB) ? t[128] : 1'b0;
    x.z   = (t[127:0] == 128'd0);
    x.s   = t[127];
    x.e   = (op > OP_MAX);
    x.tag = tag;
    return x;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Behavioural ALU: result is visible the cycle after the inputs are presented
  always @(posedge clk) begin
    logic [128:0] t;
    t = alu_calc(alu_opcode, alu_input1, alu_input2, alu_shift);
    alu_result <= t[127:0];
    alu_carry  <= t[128];
  end

  // Handshake monitor: expected record per accept, observed record per pop
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready)
      exp_q.push_back(exp_rsp(cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag));
    if (rst_n && rsp_valid && rsp_ready)
      got_q.push_back(rsp_t'({rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag}));
  end

  // Present one command and wait (bounded) until it is accepted; leaves cmd_valid high
  task automatic send(input logic [3:0] op, input logic [127:0] a, input logic [127:0] b,
                      input logic [4:0] sh, input logic [3:0] tag, output int waits);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shift = sh; cmd_tag = tag; cmd_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!cmd_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waits);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    n_cmp++;
    if (got_q.size() < n) begin
      n_fail++;
      $display("FAIL wait_rsp: got %0d responses, required %0d", got_q.size(), n);
    end
  endtask

  task automatic drain();
    int c = 0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    while (busy && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_busy: busy=%b, required 0", busy);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_opcode = 4'd0; cmd_a = 128'd0; cmd_b = 128'd0; cmd_shift = 5'd0; cmd_tag = 4'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: valid/busy/ready=%b, required 000", {rsp_valid, busy, cmd_ready});
    end
    n_cmp++;
    if ({alu_opcode, alu_input1, alu_input2, alu_shift} !== 265'd0) begin
      n_fail++;
      $display("FAIL reset_alu: op=%h in1=%h in2=%h sh=%h, required all 0",
               alu_opcode, alu_input1, alu_input2, alu_shift);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready=%b after release, required 1", cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_carry();
    int w;
    rsp_ready = 1'b1;
    send(OP_ADD, {128{1'b1}}, 128'd1, 5'd0, 4'd3, w);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL add_lat1: valid/busy=%b, required 01", {rsp_valid, busy});
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_lat2: rsp_valid=%b, required 0", rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL add_lat3: rsp_valid=%b, required 1", rsp_valid);
    end
    n_cmp++;
    if ({rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag} !== {128'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL add_rsp: r=%h c%b z%b s%b e%b t%h, required r=0 c1 z1 s0 e0 t3",
               rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_back_to_back();
    int   w0, w1, w2, w3;
    rsp_t g;
    rsp_t e [4];
    e[0] = rsp_t'({128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1});
    e[1] = rsp_t'({128'd12, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2});
    e[2] = rsp_t'({128'd16, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3});
    e[3] = rsp_t'({128'd1,  1'b0, 1'b0, 1'b0, 1'b0, 4'd4});
    rsp_ready = 1'b1;
    send(OP_SUB, 128'd5,    128'd7, 5'd0, 4'd1, w0);
    send(OP_MUL, 128'd3,    128'd4, 5'd0, 4'd2, w1);
    send(OP_SLL, 128'd1,    128'd0, 5'd4, 4'd3, w2);
    send(OP_SRL, 128'h80,   128'd0, 5'd7, 4'd4, w3);
    cmd_valid = 1'b0;
    n_cmp++;
    if (w0 + w1 + w2 + w3 != 0) begin
      n_fail++;
      $display("FAIL b2b_ready: %0d stall cycles, required 0", w0 + w1 + w2 + w3);
    end
    wait_rsp(4, 20);
    for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      n_cmp++;
      if (g !== e[i]) begin
        n_fail++;
        $display("FAIL b2b_rsp%0d: got %h, required %h", i, g, e[i]);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int   idx = 0;
    logic hit;
    rsp_t g;
    rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 120 && idx < 10; cyc++) begin
      cmd_opcode = OP_ADD; cmd_a = 128'(100 + idx); cmd_b = 128'(idx);
      cmd_shift = 5'd0; cmd_tag = 4'(idx); cmd_valid = 1'b1;
      if (cyc == 10) begin
        n_cmp++;
        if (idx != 4 || cmd_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_credit: accepted %0d ready=%b, required 4 and 0", idx, cmd_ready);
        end
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      hit = cmd_ready;
      @(posedge clk); #1;
      if (hit) idx++;
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (idx != 10) begin
      n_fail++;
      $display("FAIL bp_resume: accepted %0d, required 10", idx);
    end
    wait_rsp(10, 50);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != 10) begin
      n_fail++;
      $display("FAIL bp_count: got %0d responses, required 10", got_q.size());
    end
    for (int i = 0; i < 10 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      n_cmp++;
      if (g !== rsp_t'({128'(100 + 2 * i), 1'b0, 1'b0, 1'b0, 1'b0, 4'(i)})) begin
        n_fail++;
        $display("FAIL bp_rsp%0d: got r=%0d tag=%0d, required r=%0d tag=%0d", i, g.r, g.tag, 100 + 2 * i, i);
      end
    end
    drain();
  endtask

  task automatic test_illegal();
    int   w;
    rsp_t g;
    rsp_ready = 1'b1;
    send(4'd9, 128'd5, 128'd3, 5'd0, 4'd9, w);
    cmd_valid = 1'b0;
    wait_rsp(1, 20);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      n_cmp++;
      if (g !== rsp_t'({128'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9})) begin
        n_fail++;
        $display("FAIL illegal_rsp: got %h, required r=0 c0 z1 s0 e1 t9", g);
      end
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    int   w;
    rsp_t g;
    rsp_ready = 1'b1;
    send(OP_ADD, 128'd10, 128'd20, 5'd0, 4'd1, w);
    send(OP_ADD, 128'd30, 128'd40, 5'd0, 4'd2, w);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flush: valid/busy/ready=%b, required 000", {rsp_valid, busy, cmd_ready});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != 0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stale: %0d responses valid=%b busy=%b, required 0/0/0", got_q.size(), rsp_valid, busy);
    end
    send(OP_ADD, 128'd1, 128'd1, 5'd0, 4'd6, w);
    cmd_valid = 1'b0;
    wait_rsp(1, 20);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      n_cmp++;
      if (g !== rsp_t'({128'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6})) begin
        n_fail++;
        $display("FAIL rst_add: got %h, required r=2 t6", g);
      end
    end
    drain();
  endtask

  task automatic test_random();
    localparam int N = 10000;
    int   sent = 0;
    int   cyc  = 0;
    int   sel;
    logic acc;
    rsp_t g;
    rsp_t e;
    while (sent < N && cyc < N * 8) begin
      if (!cmd_valid && $urandom_range(0, 3) != 0) begin
        sel        = $urandom_range(0, 5);
        cmd_opcode = (sel == 5) ? 4'($urandom_range(5, 15)) : 4'(sel);
        cmd_a      = rnd128();
        cmd_b      = ($urandom_range(0, 7) == 0) ? cmd_a : rnd128();
        cmd_shift  = 5'($urandom_range(0, 31));
        cmd_tag    = 4'($urandom_range(0, 15));
        cmd_valid  = 1'b1;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = cmd_valid & cmd_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp(N, 100);
    n_cmp++;
    if (sent != N || exp_q.size() != N || got_q.size() != N) begin
      n_fail++;
      $display("FAIL rnd_count: sent %0d expected %0d got %0d, required %0d each",
               sent, exp_q.size(), got_q.size(), N);
    end
    for (int i = 0; i < N && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL rnd_rsp%0d: got %h, required %h", i, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
